// File: rtl/ccip_mmio_indirect_bridge.sv
// CCI-P MMIO responder with a CMD/WDATA/RDATA/SCRATCH window. The window tunnels
// 32-bit indirect accesses onto an Avalon-MM master port.
module ccip_mmio_indirect_bridge #(
  parameter logic [14:0] CMD_IDX        = 15'd6,
  parameter logic [14:0] WDATA_IDX      = 15'd7,
  parameter logic [14:0] RDATA_IDX      = 15'd8,
  parameter logic [14:0] SCRATCH_IDX    = 15'd9,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        pClk,
  input  logic        pck_cp2af_softReset_n,
  input  logic        mmio_rd_valid,
  input  logic        mmio_wr_valid,
  input  logic [15:0] mmio_addr,
  input  logic [1:0]  mmio_len,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wdata,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic [15:0] av_address,
  output logic        av_write,
  output logic        av_read,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  input  logic        av_readdatavalid
);

  typedef enum logic [1:0] {S_IDLE, S_WR_REQ, S_RD_REQ, S_RD_WAIT} state_e;

  typedef struct packed {
    logic        dropped;
    logic        timeout;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
  } cmd_t;

  localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  cmd_t        cmd_q, cmd_d;
  logic [63:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [63:0] scratch_q, scratch_d;
  logic [15:0] av_address_q, av_address_d;
  logic [31:0] av_writedata_q, av_writedata_d;

  logic        p1_valid_q, rsp_valid_q;
  logic [8:0]  p1_tid_q, rsp_tid_q;
  logic [63:0] p1_data_q, rsp_data_q;

  logic [14:0] idx;
  logic        hi, is64, wr_lo, wr_hi, busy;
  logic [31:0] wr_hi_val;
  logic        cmd_hit, rise_wr, rise_rd, launch;
  logic [63:0] rd_word, rd_sel;

  assign idx       = mmio_addr[15:1];
  assign hi        = mmio_addr[0];
  assign is64      = (mmio_len == 2'b10);
  assign wr_lo     = mmio_wr_valid && (is64 || !hi);
  assign wr_hi     = mmio_wr_valid && (is64 || hi);
  assign wr_hi_val = is64 ? mmio_wdata[63:32] : mmio_wdata[31:0];
  assign busy      = (state_q != S_IDLE);

  // Launch is detected on the CMD write itself, so the strobe rises the very next cycle.
  assign cmd_hit = wr_lo && (idx == CMD_IDX);
  assign rise_wr = cmd_hit && mmio_wdata[16] && !cmd_q.wr;
  assign rise_rd = cmd_hit && mmio_wdata[17] && !cmd_q.rd;
  assign launch  = rise_wr || rise_rd;

  always_comb begin
    rd_word = '0;
    case (idx)
      CMD_IDX:     rd_word = {32'h0, busy, cmd_q.dropped, cmd_q.timeout, 11'h0,
                              cmd_q.rd, cmd_q.wr, cmd_q.addr};
      WDATA_IDX:   rd_word = wdata_q;
      RDATA_IDX:   rd_word = {32'h0, rdata_q};
      SCRATCH_IDX: rd_word = scratch_q;
      default:     rd_word = '0;
    endcase
    rd_sel = is64 ? rd_word : {32'h0, (hi ? rd_word[63:32] : rd_word[31:0])};
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d        = state_q;
    timer_d        = timer_q;
    cmd_d          = cmd_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    scratch_d      = scratch_q;
    av_address_d   = av_address_q;
    av_writedata_d = av_writedata_q;

    if (wr_lo && idx == WDATA_IDX)   wdata_d[31:0]    = mmio_wdata[31:0];
    if (wr_hi && idx == WDATA_IDX)   wdata_d[63:32]   = wr_hi_val;
    if (wr_lo && idx == SCRATCH_IDX) scratch_d[31:0]  = mmio_wdata[31:0];
    if (wr_hi && idx == SCRATCH_IDX) scratch_d[63:32] = wr_hi_val;

    if (cmd_hit) begin
      cmd_d.addr    = mmio_wdata[15:0];
      cmd_d.wr      = mmio_wdata[16];
      cmd_d.rd      = mmio_wdata[17];
      cmd_d.timeout = 1'b0;
      cmd_d.dropped = 1'b0;
    end
    if (launch && (busy || (rise_wr && rise_rd))) cmd_d.dropped = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          av_address_d = mmio_wdata[15:0];
          if (rise_wr) begin
            state_d        = S_WR_REQ;
            av_writedata_d = wdata_q[31:0];
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: if (!av_waitrequest) state_d = S_IDLE;
      S_RD_REQ: begin
        if (!av_waitrequest) begin
          timer_d = '0;
          if (av_readdatavalid) begin
            rdata_d = av_readdata;
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (av_readdatavalid) begin
          rdata_d = av_readdata;
          state_d = S_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          rdata_d       = TIMEOUT_DATA;
          cmd_d.timeout = 1'b1;
          state_d       = S_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pClk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!pck_cp2af_softReset_n) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      cmd_q          <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      scratch_q      <= '0;
      av_address_q   <= '0;
      av_writedata_q <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      cmd_q          <= cmd_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      scratch_q      <= scratch_d;
      av_address_q   <= av_address_d;
      av_writedata_q <= av_writedata_d;
    end
  end

  // Two-stage read pipeline; data is captured from pre-write register values.
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      p1_valid_q  <= 1'b0;
      p1_tid_q    <= '0;
      p1_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      p1_valid_q  <= mmio_rd_valid;
      p1_tid_q    <= mmio_tid;
      p1_data_q   <= rd_sel;
      rsp_valid_q <= p1_valid_q;
      rsp_tid_q   <= p1_tid_q;
      rsp_data_q  <= p1_data_q;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_tid      = rsp_tid_q;
  assign rsp_data     = rsp_data_q;
  assign av_address   = av_address_q;
  assign av_writedata = av_writedata_q;
  assign av_write     = (state_q == S_WR_REQ);
  assign av_read      = (state_q == S_RD_REQ);

endmodule

// File: tb/tb_ccip_mmio_indirect_bridge.sv
// Scoreboard bench: MMIO stimulus pushes expected responses and Avalon transfers,
// and independent monitor/slave processes pop and compare them.
module tb_ccip_mmio_indirect_bridge;

  localparam int          CMD = 6, WD = 7, RD = 8, SC = 9;
  localparam logic [31:0] TO_DATA = 32'hDEADBEEF;

  logic        pClk = 1'b0;
  logic        rst_n;
  logic        mmio_rd_valid, mmio_wr_valid;
  logic [15:0] mmio_addr;
  logic [1:0]  mmio_len;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic [15:0] av_address;
  logic        av_write, av_read;
  logic [31:0] av_writedata, av_readdata;
  logic        av_waitrequest, av_readdatavalid;

  always #5 pClk = ~pClk;

  ccip_mmio_indirect_bridge dut (
    .pClk                 (pClk),
    .pck_cp2af_softReset_n(rst_n),
    .mmio_rd_valid        (mmio_rd_valid),
    .mmio_wr_valid        (mmio_wr_valid),
    .mmio_addr            (mmio_addr),
    .mmio_len             (mmio_len),
    .mmio_tid             (mmio_tid),
    .mmio_wdata           (mmio_wdata),
    .rsp_valid            (rsp_valid),
    .rsp_tid              (rsp_tid),
    .rsp_data             (rsp_data),
    .av_address           (av_address),
    .av_write             (av_write),
    .av_read              (av_read),
    .av_writedata         (av_writedata),
    .av_readdata          (av_readdata),
    .av_waitrequest       (av_waitrequest),
    .av_readdatavalid     (av_readdatavalid)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge pClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {logic [8:0] tid; logic [63:0] data; int cyc;} rsp_t;
  typedef struct {bit wr; logic [15:0] addr; logic [31:0] data; int cyc;} xfer_t;
  rsp_t  rsp_q[$];
  xfer_t exp_xfer[$];

  // Reference register file
  logic [63:0] m_scratch, m_wdata;
  logic [31:0] m_rdata;
  logic [15:0] m_addr;
  bit          m_wr, m_rd, m_to, m_drop, m_busy;
  bit          pend_rd, pend_to;
  logic [31:0] pend_data;

  // Avalon slave behaviour knobs
  int          slv_wait = 0, slv_lat = 1;
  logic [31:0] slv_rdata = '0;
  bit          stray_req = 0;
  int          wr_hi_cycles = 0;

  int idx_tab[7] = '{6, 7, 8, 9, 3, 12, 32767};

  task automatic m_reset();
    m_scratch = '0; m_wdata = '0; m_rdata = '0; m_addr = '0;
    m_wr = 0; m_rd = 0; m_to = 0; m_drop = 0; m_busy = 0; pend_rd = 0; pend_to = 0;
  endtask

  function automatic logic [63:0] m_word(input int idx);
    case (idx)
      CMD:     return {32'h0, m_busy, m_drop, m_to, 11'h0, m_rd, m_wr, m_addr};
      WD:      return m_wdata;
      RD:      return {32'h0, m_rdata};
      SC:      return m_scratch;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] m_read(input int idx, input bit hi, input bit is64);
    logic [63:0] w;
    w = m_word(idx);
    if (is64) return w;
    return hi ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
  endfunction

  task automatic launch(input bit is_wr, input logic [15:0] addr);
    xfer_t x;
    x.wr = is_wr; x.addr = addr; x.data = is_wr ? m_wdata[31:0] : 32'h0;
    x.cyc = cyc + 1 + slv_wait;
    exp_xfer.push_back(x);
    m_busy    = 1;
    pend_rd   = !is_wr;
    pend_to   = (slv_lat < 0);
    pend_data = pend_to ? TO_DATA : slv_rdata;
  endtask

  task automatic m_write(input int idx, input bit hi, input bit is64, input logic [63:0] d);
    logic [63:0] merged;
    bit up_wr, up_rd;
    if (idx == SC || idx == WD) begin
      merged = (idx == SC) ? m_scratch : m_wdata;
      if (is64)    merged = d;
      else if (hi) merged[63:32] = d[31:0];
      else         merged[31:0] = d[31:0];
      if (idx == SC) m_scratch = merged; else m_wdata = merged;
    end else if (idx == CMD && (is64 || !hi)) begin
      up_wr = d[16] && !m_wr;
      up_rd = d[17] && !m_rd;
      m_addr = d[15:0]; m_wr = d[16]; m_rd = d[17]; m_to = 0; m_drop = 0;
      if ((up_wr || up_rd) && (m_busy || (up_wr && up_rd))) m_drop = 1;
      if ((up_wr || up_rd) && !m_busy) launch(up_wr, d[15:0]);
    end
  endtask

  task automatic finish_cmd();
    m_busy = 0;
    if (pend_rd) begin
      m_rdata = pend_data;
      if (pend_to) m_to = 1;
    end
    pend_rd = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pClk); #1;
      mmio_rd_valid = 1'b0; mmio_wr_valid = 1'b0;
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input int idx, input bit hi,
                       input bit is64, input logic [63:0] d);
    logic [8:0] tid;
    rsp_t r;
    @(posedge pClk); #1;
    tid = 9'($urandom);
    mmio_rd_valid = rd; mmio_wr_valid = wr;
    mmio_addr = {idx[14:0], hi}; mmio_len = is64 ? 2'b10 : 2'b00;
    mmio_tid = tid; mmio_wdata = d;
    if (rd) begin
      r.tid = tid; r.data = m_read(idx, hi, is64); r.cyc = cyc + 2;
      rsp_q.push_back(r);
    end
    if (wr) m_write(idx, hi, is64, d);
  endtask

  task automatic wr64(input int idx, input logic [63:0] d); drive(0, 1, idx, 0, 1, d); endtask
  task automatic rd64(input int idx); drive(1, 0, idx, 0, 1, 64'h0); endtask

  task automatic complete(input int n);
    idle(n);
    finish_cmd();
    check("xfer_done", exp_xfer.size(), 0);
  endtask

  always @(negedge pClk) begin : monitor
    rsp_t e;
    if (rsp_valid) begin
      check("rsp_expected", rsp_q.size() != 0, 1);
      if (rsp_q.size() != 0) begin
        e = rsp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_tid", rsp_tid, e.tid);
        check("rsp_latency", cyc, e.cyc);
      end
    end
  end

  initial begin : slave
    int age, rd_cd;
    xfer_t e;
    age = 0; rd_cd = -1;
    av_waitrequest = 1'b0; av_readdatavalid = 1'b0; av_readdata = '0;
    forever begin
      @(posedge pClk); #1;
      av_readdatavalid = 1'b0;
      if (rd_cd == 0 || stray_req) begin
        av_readdatavalid = 1'b1;
        av_readdata      = stray_req ? 32'h0BADF00D : slv_rdata;
        stray_req        = 0;
      end
      if (rd_cd >= 0) rd_cd--;
      if (av_write) wr_hi_cycles++;
      if (av_write || av_read) begin
        age++;
        av_waitrequest = (age <= slv_wait);
        if (!av_waitrequest) begin
          check("xfer_expected", exp_xfer.size() != 0, 1);
          if (exp_xfer.size() != 0) begin
            e = exp_xfer.pop_front();
            check("xfer_kind", av_write, e.wr);
            check("xfer_addr", av_address, e.addr);
            if (e.wr) check("xfer_wdata", av_writedata, e.data);
            check("xfer_cycle", cyc, e.cyc);
          end
          if (av_read) begin
            if (slv_lat == 0) begin
              av_readdatavalid = 1'b1;
              av_readdata      = slv_rdata;
            end else if (slv_lat > 0) begin
              rd_cd = slv_lat - 1;
            end
          end
        end
      end else begin
        age = 0;
        av_waitrequest = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    rst_n = 1'b0;
    mmio_rd_valid = 0; mmio_wr_valid = 0; mmio_addr = '0; mmio_len = '0;
    mmio_tid = '0; mmio_wdata = '0;
    m_reset();
    idle(3);
    check("rst_av", {av_write, av_read, av_address, av_writedata}, 64'h0);
    check("rst_rsp", {rsp_valid, rsp_tid}, 64'h0);
    rst_n = 1'b1;
    rd64(CMD); rd64(WD); rd64(RD); rd64(SC);

    // Scratch loopback and simultaneous read/write
    wr64(SC, 64'hdeefd00fd11fdaaf);
    rd64(SC);
    drive(1, 1, SC, 0, 1, 64'h0123456789abcdef);
    rd64(SC);

    // Indirect write, minimum latency
    slv_wait = 0;
    wr64(WD, 64'h00000000DAEFCAFE);
    wr64(CMD, 64'h10000);
    wr64(CMD, 64'h0);
    complete(6);
    rd64(CMD);

    // Indirect write with 5 stall cycles
    wr_hi_cycles = 0;
    slv_wait = 5;
    wr64(WD, 64'h5555AAAA_13572468);
    wr64(CMD, 64'h1BEEF);
    wr64(CMD, 64'h0);
    complete(12);
    check("stall_strobe_cycles", wr_hi_cycles, 6);
    slv_wait = 0;

    // Indirect read, data after 7 cycles
    slv_lat = 7; slv_rdata = 32'h12345678;
    wr64(CMD, 64'h20003);
    wr64(CMD, 64'h0);
    complete(14);
    rd64(RD); rd64(CMD);

    // Data valid in the acceptance cycle, after a stall
    slv_wait = 2; slv_lat = 0; slv_rdata = 32'hCAFEF00D;
    wr64(CMD, 64'h20044);
    wr64(CMD, 64'h0);
    complete(8);
    rd64(RD);
    slv_wait = 0;

    // Stray readdatavalid while idle is ignored
    stray_req = 1;
    idle(3);
    rd64(RD);

    // Read timeout, probed around the last waiting cycle
    slv_lat = -1;
    wr64(CMD, 64'h20010);
    wr64(CMD, 64'h0);
    idle(1022);
    rd64(CMD);
    rd64(CMD);
    finish_cmd();
    rd64(CMD);
    rd64(RD);
    idle(4);
    check("timeout_xfer", exp_xfer.size(), 0);
    wr64(CMD, 64'h0);
    rd64(CMD);
    slv_lat = 1;

    // Launch errors: both bits rising, relaunch while busy, no rising edge
    wr64(CMD, 64'h30000);
    rd64(CMD);
    complete(5);
    rd64(CMD);
    wr64(CMD, 64'h0);
    slv_wait = 20;
    wr64(CMD, 64'h10005);
    wr64(CMD, 64'h0);
    wr64(CMD, 64'h20000);
    rd64(CMD);
    complete(30);
    rd64(CMD);
    slv_wait = 0;
    wr64(CMD, 64'h0);
    wr64(CMD, 64'h10000);
    complete(5);
    wr64(CMD, 64'h10000);
    idle(5);
    check("no_relaunch", exp_xfer.size(), 0);
    wr64(CMD, 64'h0);

    // 32-bit accesses and dropped RDATA write
    wr64(SC, 64'h0);
    drive(0, 1, SC, 1, 0, 64'hA5A5A5A5);
    rd64(SC);
    drive(1, 0, SC, 1, 0, 64'h0);
    drive(1, 0, SC, 0, 0, 64'h0);
    wr64(RD, 64'hFFFF_FFFF_FFFF_FFFF);
    rd64(RD);
    idle(4);

    // Reset while in RD_WAIT
    slv_lat = -1;
    wr64(CMD, 64'h20044);
    wr64(CMD, 64'h0);
    idle(10);
    @(posedge pClk); #1; rst_n = 1'b0;
    @(posedge pClk); #1; rst_n = 1'b1;
    m_reset(); exp_xfer.delete();
    check("rst_wait_av", {av_write, av_read, av_address}, 64'h0);
    rd64(CMD); rd64(WD); rd64(RD); rd64(SC);
    idle(4);

    // Reset while the read strobe is stalled
    slv_wait = 50;
    wr64(WD, 64'h1111_2222_3333_4444);
    wr64(CMD, 64'h20001);
    idle(3);
    check("rd_req_strobe", av_read, 1);
    @(posedge pClk); #1; rst_n = 1'b0;
    @(posedge pClk); #1; rst_n = 1'b1;
    check("rst_req_drop", {av_read, av_address}, 64'h0);
    m_reset(); exp_xfer.delete();
    slv_wait = 0; slv_lat = 1;
    rd64(CMD); rd64(WD);
    idle(4);

    // Random register traffic
    for (int i = 0; i < 300; i++) begin
      int idx;
      bit do_rd, do_wr, hi, is64;
      idx   = idx_tab[$urandom_range(0, 6)];
      do_rd = 1'($urandom_range(0, 1));
      do_wr = (idx != CMD) && 1'($urandom_range(0, 1));
      hi    = 1'($urandom_range(0, 1));
      is64  = 1'($urandom_range(0, 1));
      if (!do_rd && !do_wr) idle(1);
      else drive(do_rd, do_wr, idx, hi, is64, {$urandom, $urandom});
    end
    idle(3);

    // Random indirect commands
    for (int i = 0; i < 30; i++) begin
      bit is_wr;
      logic [15:0] a;
      slv_wait  = $urandom_range(0, 3);
      slv_lat   = $urandom_range(0, 5);
      slv_rdata = $urandom;
      is_wr     = 1'($urandom_range(0, 1));
      a         = 16'($urandom);
      wr64(WD, {$urandom, $urandom});
      wr64(CMD, {46'h0, !is_wr, is_wr, a});
      wr64(CMD, 64'h0);
      complete(slv_wait + slv_lat + 6);
      rd64(RD); rd64(CMD);
    end

    idle(10);
    check("rsp_drained", rsp_q.size(), 0);
    check("xfer_drained", exp_xfer.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
